menu_controller: RTL and testbench
==================================

Name: menu_controller

Overview:
- Upstream stage of the on-screen settings menu.
- Turns four raw push-buttons into menu navigation and value edits.
- Holds the greenhouse setpoints (temperature, humidity, sunrise time) and a free-running time-of-day clock.
- Drives the state/value inputs of the menu display stage directly; outputs are registered and stable for a whole frame unless a press or clock tick occurs.

Parameters:
CLK_HZ, 25000000, clk cycles per second for the time-of-day prescaler
DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a button level change (>=2)
TEMP_MIN, 40, lower saturation of set_temp
TEMP_MAX, 110, upper saturation of set_temp (<=999)
TEMP_INIT, 72, set_temp reset value
HUM_MIN, 0, lower saturation of set_hum
HUM_MAX, 99, upper saturation of set_hum (<=99)
HUM_INIT, 50, set_hum reset value
SUNRISE_H_INIT, 6, sunrise_hours reset value
SUNRISE_M_INIT, 30, sunrise_minutes reset value

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock, asynchronous active-low reset
btn_up  input  1  raw button, active-high, asynchronous, bouncing
btn_down  input  1  raw button, as above
btn_left  input  1  raw button, as above
btn_right  input  1  raw button, as above
state  output  4  selected field: 0 temp, 1 hum, 2 time hours, 3 time minutes, 4 sunrise hours, 5 sunrise minutes
set_temp  output  12  temperature setpoint, binary
set_hum  output  8  humidity setpoint, binary
time_hours  output  5  current hour, 0..23
time_minutes  output  6  current minute, 0..59
sunrise_hours  output  5  sunrise hour, 0..23
sunrise_minutes  output  6  sunrise minute, 0..59
minute_tick  output  1  one-cycle pulse on each natural minute rollover

Behaviour:
Reset (async assert, sync-released by flops):
- state=0, set_temp=TEMP_INIT, set_hum=HUM_INIT, time=00:00, sunrise=SUNRISE_H_INIT:SUNRISE_M_INIT, minute_tick=0.
- Synchronisers, debounced levels, press pulses, prescaler and seconds counter all clear to 0.

Button front end (per button, identical):
- 2-flop synchroniser, then a debouncer holding a debounced level `deb` and a counter.
- Counter increments while the synchronised input differs from `deb`. It clears whenever they match.
- When the input has differed for DEBOUNCE_CYCLES consecutive cycles, `deb` takes the input value and the counter clears.
- A press pulse is a registered 1-cycle pulse on `deb` 0->1, asserted the same cycle `deb` rises. Release generates nothing.
- Latency: raw rising edge to press pulse = DEBOUNCE_CYCLES+2 edges (+1 for metastability resolution).
- A button held through reset release yields exactly one press after debounce.

Navigation (press pulses, evaluated each cycle):
- right: state+1, 5->0 wrap. left: state-1, 0->5 wrap.
- left and right in the same cycle: no state change.
- Any state value 6..15 (unreachable) goes to 0 on the next cycle.

Edit (up/down act on the field selected by state):
- Navigation has priority. If left or right pulses in a cycle, any up/down pulse in that cycle is dropped.
- up and down in the same cycle: no edit.
- state 0: set_temp +/-1, saturating at TEMP_MAX/TEMP_MIN.
- state 1: set_hum +/-1, saturating at HUM_MAX/HUM_MIN.
- state 2 and 4: hours +/-1, wrapping 23<->0.
- state 3 and 5: minutes +/-1, wrapping 59<->0.
- An edit in state 3 also clears the prescaler and the seconds counter.
- Edited values appear on the outputs the cycle after the pulse.

Time-of-day:
- Prescaler counts 0..CLK_HZ-1. At wrap the seconds counter (0..59) increments.
- Seconds 59->0 is a minute rollover: minutes+1; on minutes 59->0, hours+1 with 23->0.
- minute_tick is high for the single cycle in which the new minute value is registered.
- Collision: if an edit in state 2 or 3 occurs on a rollover cycle, only the edit is applied. Minutes and hours take the edited value, and minute_tick stays 0 that cycle.
- The seconds counter still wraps normally on a state-2 edit.
- Sunrise edits never interact with the rollover.

Reset mid-operation: all registers return immediately to reset values; a partially debounced press is discarded.

Test Plan:
1. Use CLK_HZ=10 and DEBOUNCE_CYCLES=4 for all scenarios. Apply reset -> state 0, set_temp 72, set_hum 50, time 0:00, sunrise 6:30, minute_tick 0.
2. Six clean btn_right presses -> state steps 1,2,3,4,5,0. Then one btn_left -> 5.
3. btn_up toggles every 2 cycles for 20 cycles, then holds high 10 cycles -> exactly one press. set_temp goes 72->73, once, no further increments while held.
4. In state 0, 40 up presses -> set_temp 110 and holds. In state 1, 60 down presses -> set_hum 0 and holds.
5. Run 600 cycles from reset -> exactly one minute_tick, time 0:01. Edit time to 23:59, which clears the seconds counter, then run 600 cycles -> time 0:00 with one minute_tick.
6. Collisions:
   - In state 0, btn_right and btn_up pulse on the same cycle -> state 1, set_temp unchanged.
   - In state 3, an up press lands on a rollover cycle with minutes=10 -> minutes 11, minute_tick 0, next tick 600 cycles later.

Source files
------------

// File: rtl/menu_controller.sv
// Settings-menu front end: debounces four push-buttons, walks the selected
// field, edits the greenhouse setpoints and keeps a time-of-day clock.
// Every output comes straight from a register.
module menu_controller #(
    parameter int CLK_HZ          = 25000000,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TEMP_MIN        = 40,
    parameter int TEMP_MAX        = 110,
    parameter int TEMP_INIT       = 72,
    parameter int HUM_MIN         = 0,
    parameter int HUM_MAX         = 99,
    parameter int HUM_INIT        = 50,
    parameter int SUNRISE_H_INIT  = 6,
    parameter int SUNRISE_M_INIT  = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [3:0]  state,
    output logic [11:0] set_temp,
    output logic [7:0]  set_hum,
    output logic [4:0]  time_hours,
    output logic [5:0]  time_minutes,
    output logic [4:0]  sunrise_hours,
    output logic [5:0]  sunrise_minutes,
    output logic        minute_tick
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [11:0]   T_MIN      = 12'(TEMP_MIN);
    localparam logic [11:0]   T_MAX      = 12'(TEMP_MAX);
    localparam logic [7:0]    H_MIN      = 8'(HUM_MIN);
    localparam logic [7:0]    H_MAX      = 8'(HUM_MAX);

    // Button bit order: 0 up, 1 down, 2 left, 3 right
    logic [3:0]    btn_raw_s;
    logic [3:0]    sync1_r;
    logic [3:0]    sync2_r;
    logic [3:0]    deb_r;
    logic [3:0]    press_r;
    logic [DW-1:0] cnt_r [4];

    logic [3:0]    state_r,   state_nxt_s;
    logic [11:0]   temp_r,    temp_nxt_s;
    logic [7:0]    hum_r,     hum_nxt_s;
    logic [4:0]    hrs_r,     hrs_nxt_s;
    logic [5:0]    min_r,     min_nxt_s;
    logic [4:0]    sun_h_r,   sun_h_nxt_s;
    logic [5:0]    sun_m_r,   sun_m_nxt_s;
    logic          tick_r,    tick_nxt_s;
    logic [PW-1:0] presc_r,   presc_nxt_s;
    logic [5:0]    sec_r,     sec_nxt_s;

    logic nav_any_s;
    logic edit_s;
    logic edit_up_s;
    logic presc_wrap_s;
    logic rollover_s;

    function automatic logic [4:0] hour_step(input logic [4:0] h, input logic up);
        logic [4:0] r;
        if (up) begin
            r = (h >= 5'd23) ? 5'd0 : h + 5'd1;
        end else begin
            r = (h == 5'd0) ? 5'd23 : h - 5'd1;
        end
        return r;
    endfunction

    function automatic logic [5:0] min_step(input logic [5:0] m, input logic up);
        logic [5:0] r;
        if (up) begin
            r = (m >= 6'd59) ? 6'd0 : m + 6'd1;
        end else begin
            r = (m == 6'd0) ? 6'd59 : m - 6'd1;
        end
        return r;
    endfunction

    function automatic logic [11:0] temp_step(input logic [11:0] t, input logic up);
        logic [11:0] r;
        if (up) begin
            r = (t >= T_MAX) ? T_MAX : t + 12'd1;
        end else begin
            r = (t <= T_MIN) ? T_MIN : t - 12'd1;
        end
        return r;
    endfunction

    function automatic logic [7:0] hum_step(input logic [7:0] v, input logic up);
        logic [7:0] r;
        if (up) begin
            r = (v >= H_MAX) ? H_MAX : v + 8'd1;
        end else begin
            r = (v <= H_MIN) ? H_MIN : v - 8'd1;
        end
        return r;
    endfunction

    assign btn_raw_s = {btn_right, btn_left, btn_down, btn_up};

    // Synchronise raw buttons, debounce by run length, emit one pulse per accepted rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
            deb_r   <= 4'b0000;
            press_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= {DW{1'b0}};
            end
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (cnt_r[i] == DEB_LAST) begin
                        deb_r[i]   <= sync2_r[i];
                        cnt_r[i]   <= {DW{1'b0}};
                        press_r[i] <= sync2_r[i];
                    end else begin
                        cnt_r[i]   <= cnt_r[i] + DW'(1);
                        press_r[i] <= 1'b0;
                    end
                end else begin
                    cnt_r[i]   <= {DW{1'b0}};
                    press_r[i] <= 1'b0;
                end
            end
        end
    end

    // Navigation wins over edits; opposing presses cancel
    assign nav_any_s    = press_r[2] | press_r[3];
    assign edit_s       = ~nav_any_s & (press_r[0] ^ press_r[1]);
    assign edit_up_s    = press_r[0];
    assign presc_wrap_s = (presc_r == PRESC_LAST);
    assign rollover_s   = presc_wrap_s && (sec_r == 6'd59);

    // Next selected field, with recovery from unreachable encodings
    always_comb begin
        state_nxt_s = state_r;
        if (state_r > 4'd5) begin
            state_nxt_s = 4'd0;
        end else if (press_r[3] && !press_r[2]) begin
            state_nxt_s = (state_r == 4'd5) ? 4'd0 : state_r + 4'd1;
        end else if (press_r[2] && !press_r[3]) begin
            state_nxt_s = (state_r == 4'd0) ? 4'd5 : state_r - 4'd1;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Next field values: clock advance first, then an edit overrides its own field
    always_comb begin
        temp_nxt_s  = temp_r;
        hum_nxt_s   = hum_r;
        sun_h_nxt_s = sun_h_r;
        sun_m_nxt_s = sun_m_r;
        hrs_nxt_s   = hrs_r;
        min_nxt_s   = min_r;
        tick_nxt_s  = rollover_s;
        presc_nxt_s = presc_r;
        sec_nxt_s   = sec_r;

        if (presc_wrap_s) begin
            presc_nxt_s = {PW{1'b0}};
            sec_nxt_s   = (sec_r == 6'd59) ? 6'd0 : sec_r + 6'd1;
        end else begin
            presc_nxt_s = presc_r + PW'(1);
            sec_nxt_s   = sec_r;
        end

        if (rollover_s) begin
            min_nxt_s = min_step(min_r, 1'b1);
            hrs_nxt_s = (min_r == 6'd59) ? hour_step(hrs_r, 1'b1) : hrs_r;
        end else begin
            min_nxt_s = min_r;
            hrs_nxt_s = hrs_r;
        end

        if (edit_s) begin
            case (state_r)
                4'd0: temp_nxt_s = temp_step(temp_r, edit_up_s);
                4'd1: hum_nxt_s  = hum_step(hum_r, edit_up_s);
                4'd2: begin
                    // An hour edit swallows a coinciding rollover
                    hrs_nxt_s  = hour_step(hrs_r, edit_up_s);
                    min_nxt_s  = min_r;
                    tick_nxt_s = 1'b0;
                end
                4'd3: begin
                    // Setting minutes restarts the current minute from zero seconds
                    min_nxt_s   = min_step(min_r, edit_up_s);
                    hrs_nxt_s   = hrs_r;
                    tick_nxt_s  = 1'b0;
                    presc_nxt_s = {PW{1'b0}};
                    sec_nxt_s   = 6'd0;
                end
                4'd4: sun_h_nxt_s = hour_step(sun_h_r, edit_up_s);
                4'd5: sun_m_nxt_s = min_step(sun_m_r, edit_up_s);
                default: begin
                    temp_nxt_s = temp_r;
                end
            endcase
        end else begin
            temp_nxt_s = temp_r;
        end
    end

    // Register navigation state, setpoints and time-of-day
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= 4'd0;
            temp_r  <= 12'(TEMP_INIT);
            hum_r   <= 8'(HUM_INIT);
            hrs_r   <= 5'd0;
            min_r   <= 6'd0;
            sun_h_r <= 5'(SUNRISE_H_INIT);
            sun_m_r <= 6'(SUNRISE_M_INIT);
            tick_r  <= 1'b0;
            presc_r <= {PW{1'b0}};
            sec_r   <= 6'd0;
        end else begin
            state_r <= state_nxt_s;
            temp_r  <= temp_nxt_s;
            hum_r   <= hum_nxt_s;
            hrs_r   <= hrs_nxt_s;
            min_r   <= min_nxt_s;
            sun_h_r <= sun_h_nxt_s;
            sun_m_r <= sun_m_nxt_s;
            tick_r  <= tick_nxt_s;
            presc_r <= presc_nxt_s;
            sec_r   <= sec_nxt_s;
        end
    end

    assign state           = state_r;
    assign set_temp        = temp_r;
    assign set_hum         = hum_r;
    assign time_hours      = hrs_r;
    assign time_minutes    = min_r;
    assign sunrise_hours   = sun_h_r;
    assign sunrise_minutes = sun_m_r;
    assign minute_tick     = tick_r;

endmodule

// File: tb/tb_menu_controller.sv
// Bench for menu_controller: scripted scenarios plus randomized button
// activity, all checked against a minute-of-day reference model.
module tb_menu_controller;

    localparam int CLK_HZ  = 10;
    localparam int DEB     = 4;
    localparam int MIN_CYC = CLK_HZ * 60;

    logic        clk;
    logic        rst_n;
    logic        btn_up, btn_down, btn_left, btn_right;
    logic [3:0]  state;
    logic [11:0] set_temp;
    logic [7:0]  set_hum;
    logic [4:0]  time_hours;
    logic [5:0]  time_minutes;
    logic [4:0]  sunrise_hours;
    logic [5:0]  sunrise_minutes;
    logic        minute_tick;

    int checks;
    int errors;

    menu_controller #(
        .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB),
        .TEMP_MIN(40), .TEMP_MAX(110), .TEMP_INIT(72),
        .HUM_MIN(0), .HUM_MAX(99), .HUM_INIT(50),
        .SUNRISE_H_INIT(6), .SUNRISE_M_INIT(30)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .state(state), .set_temp(set_temp), .set_hum(set_hum),
        .time_hours(time_hours), .time_minutes(time_minutes),
        .sunrise_hours(sunrise_hours), .sunrise_minutes(sunrise_minutes),
        .minute_tick(minute_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: times kept as minute-of-day, the clock as cycles into the minute
    logic [3:0] raw, m_s1, m_s2, m_deb, m_press;
    int m_run [4];
    int m_state, m_temp, m_hum, m_tod, m_sun, m_phase;
    logic m_tick;
    logic m_nav, m_ed, m_roll;
    int m_dir;
    logic [46:0] dut_vec, mdl_vec;

    assign raw = {btn_right, btn_left, btn_down, btn_up};

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction
    function automatic int hour_edit(input int t, input int d);
        return (((t / 60) + d + 24) % 24) * 60 + (t % 60);
    endfunction
    function automatic int min_edit(input int t, input int d);
        return (t / 60) * 60 + (((t % 60) + d + 60) % 60);
    endfunction

    always_comb begin
        m_nav  = m_press[2] | m_press[3];
        m_ed   = !m_nav && (m_press[0] != m_press[1]);
        m_dir  = m_press[0] ? 1 : -1;
        m_roll = (m_phase == MIN_CYC - 1);
        mdl_vec = {4'(m_state), 12'(m_temp), 8'(m_hum), 5'(m_tod / 60), 6'(m_tod % 60),
                   5'(m_sun / 60), 6'(m_sun % 60), m_tick};
        dut_vec = {state, set_temp, set_hum, time_hours, time_minutes,
                   sunrise_hours, sunrise_minutes, minute_tick};
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= 4'b0; m_s2 <= 4'b0; m_deb <= 4'b0; m_press <= 4'b0;
            for (int i = 0; i < 4; i++) m_run[i] <= 0;
            m_state <= 0; m_temp <= 72; m_hum <= 50; m_tod <= 0;
            m_sun <= 6 * 60 + 30; m_phase <= 0; m_tick <= 1'b0;
        end else begin
            m_s1 <= raw;
            m_s2 <= m_s1;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] == m_deb[i]) begin
                    m_run[i] <= 0; m_press[i] <= 1'b0;
                end else if (m_run[i] + 1 == DEB) begin
                    m_deb[i] <= m_s2[i]; m_run[i] <= 0; m_press[i] <= m_s2[i];
                end else begin
                    m_run[i] <= m_run[i] + 1; m_press[i] <= 1'b0;
                end
            end
            if (m_press[3] && !m_press[2]) m_state <= (m_state + 1) % 6;
            else if (m_press[2] && !m_press[3]) m_state <= (m_state + 5) % 6;
            if (m_ed && m_state == 0) m_temp <= clamp(m_temp + m_dir, 40, 110);
            if (m_ed && m_state == 1) m_hum <= clamp(m_hum + m_dir, 0, 99);
            if (m_ed && m_state == 4) m_sun <= hour_edit(m_sun, m_dir);
            if (m_ed && m_state == 5) m_sun <= min_edit(m_sun, m_dir);
            m_phase <= (m_ed && m_state == 3) ? 0 : (m_phase + 1) % MIN_CYC;
            if (m_ed && m_state == 2) m_tod <= hour_edit(m_tod, m_dir);
            else if (m_ed && m_state == 3) m_tod <= min_edit(m_tod, m_dir);
            else if (m_roll) m_tod <= (m_tod + 1) % 1440;
            m_tick <= m_roll && !(m_ed && (m_state == 2 || m_state == 3));
        end
    end

    task automatic do_reset();
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_up = v;
            1: btn_down = v;
            2: btn_left = v;
            default: btn_right = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        repeat (DEB + 4) @(negedge clk);
        set_btn(b, 1'b0);
        repeat (DEB + 4) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [46:0] exp_v;
        do_reset();
        exp_v = {4'd0, 12'd72, 8'd50, 5'd0, 6'd0, 5'd6, 6'd30, 1'b0};
        checks++;
        if (dut_vec !== exp_v) begin
            errors++; $display("FAIL reset_values got %h exp %h", dut_vec, exp_v);
        end
        checks++;
        if (dut_vec !== mdl_vec) begin
            errors++; $display("FAIL reset_model got %h exp %h", dut_vec, mdl_vec);
        end
    endtask

    task automatic test_nav();
        for (int i = 0; i < 6; i++) begin
            press(3);
            checks++;
            if (state !== 4'((i + 1) % 6)) begin
                errors++; $display("FAIL nav_right got %0d exp %0d", state, (i + 1) % 6);
            end
        end
        press(2);
        checks++;
        if (state !== 4'd5) begin
            errors++; $display("FAIL nav_left_wrap got %0d exp 5", state);
        end
    endtask

    task automatic test_bounce();
        press(3);
        for (int k = 0; k < 10; k++) begin
            btn_up = (k % 2 == 0);
            repeat (2) @(negedge clk);
        end
        btn_up = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (set_temp !== 12'd73) begin
            errors++; $display("FAIL bounce_once got %0d exp 73", set_temp);
        end
        repeat (20) @(negedge clk);
        btn_up = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (set_temp !== 12'd73 || dut_vec !== mdl_vec) begin
            errors++; $display("FAIL bounce_hold got %0d exp 73 (vec %h exp %h)", set_temp, dut_vec, mdl_vec);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 40; i++) press(0);
        checks++;
        if (set_temp !== 12'd110) begin
            errors++; $display("FAIL temp_max got %0d exp 110", set_temp);
        end
        press(3);
        for (int i = 0; i < 60; i++) press(1);
        checks++;
        if (set_hum !== 8'd0) begin
            errors++; $display("FAIL hum_min got %0d exp 0", set_hum);
        end
        checks++;
        if (dut_vec !== mdl_vec) begin
            errors++; $display("FAIL sat_model got %h exp %h", dut_vec, mdl_vec);
        end
    endtask

    task automatic test_minute();
        int ticks;
        do_reset();
        ticks = 0;
        for (int i = 0; i < MIN_CYC; i++) begin
            @(negedge clk);
            if (minute_tick === 1'b1) ticks++;
        end
        checks++;
        if (ticks != 1 || time_hours !== 5'd0 || time_minutes !== 6'd1) begin
            errors++; $display("FAIL first_minute ticks %0d time %0d:%0d exp 1 tick 0:1", ticks, time_hours, time_minutes);
        end
        press(3); press(3); press(1);
        press(3); press(1); press(1);
        checks++;
        if (time_hours !== 5'd23 || time_minutes !== 6'd59) begin
            errors++; $display("FAIL set_2359 got %0d:%0d exp 23:59", time_hours, time_minutes);
        end
        ticks = 0;
        for (int i = 0; i < MIN_CYC; i++) begin
            @(negedge clk);
            if (minute_tick === 1'b1) ticks++;
        end
        checks++;
        if (ticks != 1 || time_hours !== 5'd0 || time_minutes !== 6'd0) begin
            errors++; $display("FAIL day_wrap ticks %0d time %0d:%0d exp 1 tick 0:0", ticks, time_hours, time_minutes);
        end
        checks++;
        if (dut_vec !== mdl_vec) begin
            errors++; $display("FAIL minute_model got %h exp %h", dut_vec, mdl_vec);
        end
    endtask

    task automatic test_collide_nav();
        do_reset();
        btn_right = 1'b1; btn_up = 1'b1;
        repeat (DEB + 4) @(negedge clk);
        btn_right = 1'b0; btn_up = 1'b0;
        repeat (DEB + 4) @(negedge clk);
        checks++;
        if (state !== 4'd1 || set_temp !== 12'd72) begin
            errors++; $display("FAIL nav_priority state %0d temp %0d exp 1 72", state, set_temp);
        end
    endtask

    task automatic test_collide_roll();
        bit found;
        int k_tick;
        do_reset();
        press(3); press(3); press(3);
        for (int i = 0; i < 10; i++) press(0);
        checks++;
        if (time_minutes !== 6'd10) begin
            errors++; $display("FAIL preset_min got %0d exp 10", time_minutes);
        end
        found = 1'b0;
        for (int i = 0; i < MIN_CYC + 100 && !found; i++) begin
            if (m_phase == MIN_CYC - 7) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL align_timeout phase %0d exp %0d", m_phase, MIN_CYC - 7);
        end
        btn_up = 1'b1;
        k_tick = -1;
        for (int k = 1; k <= MIN_CYC + 100 && k_tick < 0; k++) begin
            @(negedge clk);
            if (k == 8) btn_up = 1'b0;
            if (k == 7) begin
                checks++;
                if (time_minutes !== 6'd11 || minute_tick !== 1'b0) begin
                    errors++; $display("FAIL roll_collide min %0d tick %0d exp 11 0", time_minutes, minute_tick);
                end
            end
            if (minute_tick === 1'b1) k_tick = k;
        end
        checks++;
        if (k_tick != 7 + MIN_CYC) begin
            errors++; $display("FAIL next_tick at %0d exp %0d", k_tick, 7 + MIN_CYC);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int seg = 0; seg < 300; seg++) begin
            int hold;
            logic [3:0] v;
            v = 4'($urandom_range(0, 15));
            btn_up = v[0]; btn_down = v[1]; btn_left = v[2]; btn_right = v[3];
            hold = $urandom_range(1, 12);
            if (seg == 150) rst_n = 1'b0;
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                rst_n = 1'b1;
                checks++;
                if (dut_vec !== mdl_vec) begin
                    errors++; $display("FAIL random_model seg %0d got %h exp %h", seg, dut_vec, mdl_vec);
                end
            end
        end
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        test_reset();
        test_nav();
        test_bounce();
        test_saturation();
        test_minute();
        test_collide_nav();
        test_collide_roll();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
